// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency sweep sequencer: state encoding,
// default sweep geometry and a sizing helper for the phase timer.
package sweep_pkg;

   localparam int unsigned BINS_DEF   = 16;
   localparam int unsigned SETTLE_DEF = 4;
   localparam int unsigned DWELL_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_DWELL  = 3'd2,
      ST_REPORT = 3'd3,
      ST_DONE   = 3'd4
   } sweep_state_t;

   // Counter width able to hold the longer of the two phase lengths.
   function automatic int unsigned timer_width(input int unsigned settle,
                                               input int unsigned dwell);
      return $clog2(((settle > dwell) ? settle : dwell) + 1);
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing the settle and dwell phases.
// Ports:
//   clk      - clock, rising edge
//   RE       - asynchronous active-high reset, clears the count
//   load     - load load_val (has priority over en)
//   load_val - value loaded into the counter
//   en       - decrement enable; the count saturates at zero
//   zero_c   - combinational flag, count is zero
module phase_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         RE,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero_c
);

   logic [W-1:0] count;

   // Down-counter with load priority and saturation at zero.
   always_ff @(posedge clk or posedge RE) begin
      if (RE) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency sweep sequencer: steps a bin index through BINS bins, ascending
// or descending, spending SETTLE cycles settling and DWELL cycles measuring
// per bin, then reporting each bin through a valid/ready handshake.
// Ports:
//   clk       - clock, rising edge
//   RE        - asynchronous active-high reset
//   start     - sweep request, sampled in IDLE only
//   dir       - 0 ascending, 1 descending; sampled with start
//   abort     - cancel the sweep in progress
//   bin_ready - downstream accepts the current bin result
//   bin_idx   - current bin index
//   settle_en - high during settle cycles
//   dwell_en  - measurement datapath enable, high during dwell cycles
//   bin_valid - bin result available to downstream
//   busy      - high in every state except IDLE
//   done      - one-cycle pulse on normal sweep completion
module sweep_sequencer
   import sweep_pkg::*;
#(
   parameter int unsigned BINS   = BINS_DEF,
   parameter int unsigned SETTLE = SETTLE_DEF,
   parameter int unsigned DWELL  = DWELL_DEF
) (
   input  logic                    clk,
   input  logic                    RE,
   input  logic                    start,
   input  logic                    dir,
   input  logic                    abort,
   input  logic                    bin_ready,
   output logic [$clog2(BINS)-1:0] bin_idx,
   output logic                    settle_en,
   output logic                    dwell_en,
   output logic                    bin_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned IW = $clog2(BINS);
   localparam int unsigned TW = timer_width(SETTLE, DWELL);

   localparam logic [IW-1:0] IDX_LAST  = IW'(BINS - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
   localparam logic [TW-1:0] DWELL_LD  = TW'(DWELL - 1);

   sweep_state_t  state, state_nxt;
   logic          dir_q, dir_nxt;
   logic [IW-1:0] idx_nxt;
   logic [IW-1:0] step_idx_c;
   logic          last_bin_c;
   logic          tmr_load, tmr_en, tmr_zero_c;
   logic [TW-1:0] tmr_val;
   logic          settle_en_c, dwell_en_c, bin_valid_c, busy_c, done_c;

   phase_timer #(.W(TW)) u_phase_timer (
      .clk      (clk),
      .RE       (RE),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero_c   (tmr_zero_c)
   );

   // Next bin index, modulo BINS, in the latched direction.
   always_comb begin
      if (dir_q) begin
         step_idx_c = (bin_idx == '0) ? IDX_LAST : bin_idx - IW'(1);
      end else begin
         step_idx_c = (bin_idx == IDX_LAST) ? '0 : bin_idx + IW'(1);
      end
   end

   assign last_bin_c = dir_q ? (bin_idx == '0) : (bin_idx == IDX_LAST);

   // State, latched direction, bin index and registered outputs.
   always_ff @(posedge clk or posedge RE) begin
      if (RE) begin
         state     <= ST_IDLE;
         dir_q     <= 1'b0;
         bin_idx   <= '0;
         settle_en <= 1'b0;
         dwell_en  <= 1'b0;
         bin_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         dir_q     <= dir_nxt;
         bin_idx   <= idx_nxt;
         settle_en <= settle_en_c;
         dwell_en  <= dwell_en_c;
         bin_valid <= bin_valid_c;
         busy      <= busy_c;
         done      <= done_c;
      end
   end

   // Next-state, bin stepping and phase timer control.
   always_comb begin
      state_nxt = state;
      dir_nxt   = dir_q;
      idx_nxt   = bin_idx;
      tmr_load  = 1'b0;
      tmr_val   = SETTLE_LD;
      tmr_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               state_nxt = ST_SETTLE;
               dir_nxt   = dir;
               idx_nxt   = dir ? IDX_LAST : '0;
               tmr_load  = 1'b1;
               tmr_val   = SETTLE_LD;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (tmr_zero_c) begin
               state_nxt = ST_DWELL;
               tmr_load  = 1'b1;
               tmr_val   = DWELL_LD;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_DWELL: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (tmr_zero_c) begin
               state_nxt = ST_REPORT;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_REPORT: begin
            // Abort wins over a handshake in the same cycle.
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (bin_valid && bin_ready) begin
               if (last_bin_c) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_SETTLE;
                  idx_nxt   = step_idx_c;
                  tmr_load  = 1'b1;
                  tmr_val   = SETTLE_LD;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so outputs line up with the state register.
   always_comb begin
      settle_en_c = 1'b0;
      dwell_en_c  = 1'b0;
      bin_valid_c = 1'b0;
      done_c      = 1'b0;
      busy_c      = (state_nxt != ST_IDLE);
      case (state_nxt)
         ST_SETTLE: settle_en_c = 1'b1;
         ST_DWELL:  dwell_en_c  = 1'b1;
         ST_REPORT: bin_valid_c = 1'b1;
         ST_DONE:   done_c      = 1'b1;
         default:   ;
      endcase
   end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: builds the expected per-cycle output trace of a
// sweep from the bin/phase rules and compares the DUT against it cycle by cycle.
module tb_sweep_sequencer;

   localparam int unsigned BINS   = 4;
   localparam int unsigned SETTLE = 2;
   localparam int unsigned DWELL  = 3;
   localparam int unsigned IW     = $clog2(BINS);
   localparam int unsigned PERIOD = SETTLE + DWELL + 1;

   logic          clk;
   logic          RE;
   logic          start;
   logic          dir;
   logic          abort;
   logic          bin_ready;
   logic [IW-1:0] bin_idx;
   logic          settle_en;
   logic          dwell_en;
   logic          bin_valid;
   logic          busy;
   logic          done;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          valid;
      logic          dwell;
      logic          settle;
      logic [IW-1:0] idx;
   } obs_t;

   obs_t obs;
   obs_t exp_q[$];
   bit   rdy_q[$];
   int   stalls[BINS];
   int   total;
   int   bad;
   int   busy_cycles;
   int   done_seen;
   int   done_exp;
   int   last_idx;

   sweep_sequencer #(
      .BINS   (BINS),
      .SETTLE (SETTLE),
      .DWELL  (DWELL)
   ) dut (
      .clk       (clk),
      .RE        (RE),
      .start     (start),
      .dir       (dir),
      .abort     (abort),
      .bin_ready (bin_ready),
      .bin_idx   (bin_idx),
      .settle_en (settle_en),
      .dwell_en  (dwell_en),
      .bin_valid (bin_valid),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {busy, done, bin_valid, dwell_en, settle_en, bin_idx};

   always @(negedge clk) begin
      if (done === 1'b1) done_seen++;
   end

   function automatic obs_t mk(bit b, bit d, bit v, bit dw, bit s, int idx);
      return {b, d, v, dw, s, IW'(idx)};
   endfunction

   // Reference trace: bins visited in order, each SETTLE settle cycles, DWELL
   // dwell cycles, then stalls+1 report cycles, followed by one done cycle.
   task automatic build_trace(input bit d);
      exp_q.delete();
      rdy_q.delete();
      for (int n = 0; n < int'(BINS); n++) begin
         int b;
         b = d ? int'(BINS) - 1 - n : n;
         for (int s = 0; s < int'(SETTLE); s++) begin
            exp_q.push_back(mk(1, 0, 0, 0, 1, b));
            rdy_q.push_back(1'($urandom_range(0, 1)));
         end
         for (int w = 0; w < int'(DWELL); w++) begin
            exp_q.push_back(mk(1, 0, 0, 1, 0, b));
            rdy_q.push_back(1'($urandom_range(0, 1)));
         end
         for (int r = 0; r <= stalls[n]; r++) begin
            exp_q.push_back(mk(1, 0, 1, 0, 0, b));
            rdy_q.push_back(r == stalls[n]);
         end
      end
      exp_q.push_back(mk(1, 1, 0, 0, 0, d ? 0 : int'(BINS) - 1));
      rdy_q.push_back(1'($urandom_range(0, 1)));
   endtask

   // One sweep; junk start/dir during the sweep must be ignored.
   task automatic run_sweep(input bit d, input int abort_at, input string tag);
      int   idle_idx;
      obs_t e;
      build_trace(d);
      @(negedge clk);
      start     = 1'b1;
      dir       = d;
      abort     = 1'b0;
      bin_ready = 1'($urandom_range(0, 1));
      busy_cycles = 0;
      idle_idx  = int'(exp_q[exp_q.size() - 1].idx);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         e = exp_q[i];
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL %s cycle %0d: got %b want %b", tag, i, obs, e);
         end
         if (busy === 1'b1) busy_cycles++;
         start     = 1'($urandom_range(0, 1));
         dir       = 1'($urandom_range(0, 1));
         bin_ready = rdy_q[i];
         if (i == abort_at) begin
            abort    = 1'b1;
            idle_idx = int'(e.idx);
            break;
         end
      end
      @(negedge clk);
      e = mk(0, 0, 0, 0, 0, idle_idx);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL %s idle after sweep: got %b want %b", tag, obs, e);
      end
      start = 1'b0;
      abort = 1'b0;
      dir   = 1'b0;
      if (abort_at < 0) done_exp++;
      last_idx = idle_idx;
   endtask

   task automatic clear_stalls();
      for (int n = 0; n < int'(BINS); n++) stalls[n] = 0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (obs !== obs_t'(0)) begin
         bad++;
         $display("FAIL reset_hold: got %b want %b", obs, obs_t'(0));
      end
      @(negedge clk);
      RE = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== obs_t'(0)) begin
         bad++;
         $display("FAIL reset_release: got %b want %b", obs, obs_t'(0));
      end
   endtask

   task automatic test_ascending();
      clear_stalls();
      run_sweep(1'b0, -1, "ascending");
      total++;
      if (busy_cycles != 25) begin
         bad++;
         $display("FAIL ascending_length: got %0d want 25", busy_cycles);
      end
   endtask

   task automatic test_descending();
      clear_stalls();
      run_sweep(1'b1, -1, "descending");
      total++;
      if (busy_cycles != 25) begin
         bad++;
         $display("FAIL descending_length: got %0d want 25", busy_cycles);
      end
   endtask

   task automatic test_stall();
      clear_stalls();
      stalls[1] = 5;
      run_sweep(1'b0, -1, "stall_bin1");
      total++;
      if (busy_cycles != 30) begin
         bad++;
         $display("FAIL stall_length: got %0d want 30", busy_cycles);
      end
   endtask

   // Abort on the middle dwell cycle of bin 2, then a fresh sweep from bin 0.
   task automatic test_abort();
      clear_stalls();
      run_sweep(1'b0, 2 * int'(PERIOD) + int'(SETTLE) + 1, "abort_dwell");
      run_sweep(1'b0, -1, "restart_after_abort");
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (obs !== mk(0, 0, 0, 0, 0, last_idx)) begin
            bad++;
            $display("FAIL start_abort_idle: got %b want %b", obs, mk(0, 0, 0, 0, 0, last_idx));
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Reset asserted between edges in the first settle cycle.
   task automatic test_async_reset();
      @(negedge clk);
      start = 1'b1;
      dir   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2;
      RE = 1'b1;
      #1;
      total++;
      if (obs !== obs_t'(0)) begin
         bad++;
         $display("FAIL async_reset: got %b want %b", obs, obs_t'(0));
      end
      @(negedge clk);
      RE = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (obs !== obs_t'(0)) begin
            bad++;
            $display("FAIL reset_stays_idle: got %b want %b", obs, obs_t'(0));
         end
      end
      last_idx = 0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         int ab;
         for (int n = 0; n < int'(BINS); n++) stalls[n] = int'($urandom_range(0, 3));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BINS * PERIOD - 1)) : -1;
         run_sweep(1'($urandom_range(0, 1)), ab, "random");
      end
   endtask

   task automatic test_back_to_back();
      clear_stalls();
      run_sweep(1'b1, -1, "b2b_first");
      run_sweep(1'b0, -1, "b2b_second");
      total++;
      if (done_seen != done_exp) begin
         bad++;
         $display("FAIL done_count: got %0d want %0d", done_seen, done_exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total     = 0;
      bad       = 0;
      done_seen = 0;
      done_exp  = 0;
      last_idx  = 0;
      RE        = 1'b1;
      start     = 1'b0;
      dir       = 1'b0;
      abort     = 1'b0;
      bin_ready = 1'b0;
      test_reset();
      test_ascending();
      test_descending();
      test_stall();
      test_abort();
      test_start_abort_idle();
      test_async_reset();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
